lsu_arbiter: RTL and testbench

- Two-requester arbiter that shares the single load/store unit port (address, store data, byte strobe, write enable, VALID/READY) between the CPU core (m0) and a DMA/loader master (m1).
- Sits between the requesters and the LSU.
- Locks the grant for the full duration of a transaction, which matters for multi-cycle SRAM-backed data memory.
- Provides fixed-priority or round-robin arbitration and a transaction timeout with an error response.

---
 rtl/singlecycle_pkg.sv | 46 ++++
 rtl/rr_arb2.sv | 37 +++
 rtl/lsu_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_lsu_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/singlecycle_pkg.sv
// -----------------------------------------------------------------------------
// singlecycle_pkg
// Shared types for the LSU arbitration slice: arbitration policy, arbiter
// state encoding, the LSU request payload bundle and a payload select helper.
// -----------------------------------------------------------------------------
package singlecycle_pkg;

    // Arbitration policy used when both requesters are valid in IDLE.
    typedef enum logic {
        ARB_FIXED = 1'b0,   // m0 always wins
        ARB_RR    = 1'b1    // alternate, starting opposite the last winner
    } arb_mode_e;

    // Arbiter lock state.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_M0 = 2'd1,
        ARB_BUSY_M1 = 2'd2
    } arb_state_e;

    // Payload forwarded to the LSU port.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        wren;
    } lsu_req_t;

    // Encoding of the last-served requester.
    localparam logic RR_M0 = 1'b0;
    localparam logic RR_M1 = 1'b1;

    // Select the payload of m1 (sel=1) or m0 (sel=0).
    function automatic lsu_req_t pick_req(input logic sel,
                                          input lsu_req_t req_m0,
                                          input lsu_req_t req_m1);
        lsu_req_t res;
        if (sel) begin
            res = req_m1;
        end else begin
            res = req_m0;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way combinational grant logic.
//   req[1:0]  in   request vector, bit 0 = m0, bit 1 = m1
//   rr_last   in   last served requester (RR_M0 / RR_M1)
//   mode      in   ARB_FIXED (m0 priority) or ARB_RR (alternating)
//   gnt[1:0]  out  one-hot grant, 2'b00 when nobody requests
// -----------------------------------------------------------------------------
module rr_arb2
    import singlecycle_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_last,
    input  arb_mode_e  mode,
    output logic [1:0] gnt
);

    // Grant selection from the current request vector.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (mode == ARB_FIXED) begin
                    gnt = 2'b01;
                end else if (rr_last == RR_M1) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/lsu_arbiter.sv
// -----------------------------------------------------------------------------
// lsu_arbiter
// Shares one LSU request port between the CPU core (m0) and a DMA/loader
// master (m1). A grant is chosen combinationally in IDLE and the winner's
// payload is forwarded in the same cycle. If the LSU does not complete
// immediately the grant is locked until i_lsu_ready or a timeout, at which
// point the locked requester receives ready with err=1 and rdata=0.
//
// Ports:
//   i_clk, i_rst_n             clock, synchronous active-low reset
//   i_mX_valid/addr/wdata/
//   i_mX_strb/wren             requester X payload (held stable until ready)
//   o_mX_ready/rdata/err       requester X completion, load data, timeout flag
//   o_lsu_valid/addr/wdata/
//   o_lsu_strb/wren            muxed request towards the LSU
//   i_lsu_ready, i_lsu_rdata   LSU completion and load data
//   o_busy                     a transaction is locked
// While i_rst_n is low every output is forced to zero.
// -----------------------------------------------------------------------------
module lsu_arbiter
    import singlecycle_pkg::*;
#(
    parameter arb_mode_e ARB_MODE    = ARB_RR,
    parameter int        TIMEOUT_CYC = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_m0_valid,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [3:0]  i_m0_strb,
    input  logic        i_m0_wren,
    output logic        o_m0_ready,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_err,

    input  logic        i_m1_valid,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [3:0]  i_m1_strb,
    input  logic        i_m1_wren,
    output logic        o_m1_ready,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_err,

    output logic        o_lsu_valid,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_lsu_wdata,
    output logic [3:0]  o_lsu_strb,
    output logic        o_lsu_wren,
    input  logic        i_lsu_ready,
    input  logic [31:0] i_lsu_rdata,

    output logic        o_busy
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    arb_state_e       state_r;
    arb_state_e       state_nxt_s;
    logic             rr_last_r;
    logic             rr_last_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic [1:0]       gnt_s;
    logic             busy_m1_s;
    logic             sel_m1_s;
    logic             lsu_valid_s;
    logic             done_m0_s;
    logic             done_m1_s;
    logic             err_s;

    lsu_req_t         req_m0_s;
    lsu_req_t         req_m1_s;
    lsu_req_t         req_sel_s;

    assign req_m0_s  = {i_m0_addr, i_m0_wdata, i_m0_strb, i_m0_wren};
    assign req_m1_s  = {i_m1_addr, i_m1_wdata, i_m1_strb, i_m1_wren};
    assign busy_m1_s = (state_r == ARB_BUSY_M1);

    // The grant vector is only consulted in IDLE; in BUSY the lock decides.
    rr_arb2 u_rr_arb2 (
        .req     ({i_m1_valid, i_m0_valid}),
        .rr_last (rr_last_r),
        .mode    (ARB_MODE),
        .gnt     (gnt_s)
    );

    // Next-state, completion and timeout decisions.
    always_comb begin
        state_nxt_s   = state_r;
        rr_last_nxt_s = rr_last_r;
        cnt_nxt_s     = cnt_r;
        sel_m1_s      = 1'b0;
        lsu_valid_s   = 1'b0;
        done_m0_s     = 1'b0;
        done_m1_s     = 1'b0;
        err_s         = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                sel_m1_s = gnt_s[1];
                if (gnt_s != 2'b00) begin
                    lsu_valid_s = 1'b1;
                    if (i_lsu_ready) begin
                        // Single-cycle access: complete without locking.
                        done_m0_s     = gnt_s[0];
                        done_m1_s     = gnt_s[1];
                        rr_last_nxt_s = gnt_s[1];
                    end else begin
                        state_nxt_s = gnt_s[1] ? ARB_BUSY_M1 : ARB_BUSY_M0;
                        cnt_nxt_s   = CNT_ONE;
                    end
                end else begin
                    lsu_valid_s = 1'b0;
                end
            end
            ARB_BUSY_M0, ARB_BUSY_M1: begin
                sel_m1_s = busy_m1_s;
                if (i_lsu_ready) begin
                    lsu_valid_s   = 1'b1;
                    done_m0_s     = ~busy_m1_s;
                    done_m1_s     = busy_m1_s;
                    rr_last_nxt_s = busy_m1_s;
                    state_nxt_s   = ARB_IDLE;
                    cnt_nxt_s     = CNT_ZERO;
                end else if (cnt_r == CNT_MAX) begin
                    // Abort: withdraw the request and report an error.
                    lsu_valid_s   = 1'b0;
                    done_m0_s     = ~busy_m1_s;
                    done_m1_s     = busy_m1_s;
                    err_s         = 1'b1;
                    rr_last_nxt_s = busy_m1_s;
                    state_nxt_s   = ARB_IDLE;
                    cnt_nxt_s     = CNT_ZERO;
                end else begin
                    lsu_valid_s = 1'b1;
                    cnt_nxt_s   = (cnt_r < CNT_MAX) ? (cnt_r + CNT_ONE) : CNT_MAX;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, last-winner and timeout counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r   <= ARB_IDLE;
            rr_last_r <= RR_M1;
            cnt_r     <= CNT_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            rr_last_r <= rr_last_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

    assign req_sel_s = pick_req(sel_m1_s, req_m0_s, req_m1_s);

    // Outputs are gated by reset so the LSU sees valid drop at once.
    assign o_lsu_valid = i_rst_n & lsu_valid_s;
    assign o_lsu_addr  = i_rst_n ? req_sel_s.addr  : 32'h0000_0000;
    assign o_lsu_wdata = i_rst_n ? req_sel_s.wdata : 32'h0000_0000;
    assign o_lsu_strb  = i_rst_n ? req_sel_s.strb  : 4'h0;
    assign o_lsu_wren  = i_rst_n & req_sel_s.wren;

    assign o_m0_ready  = i_rst_n & done_m0_s;
    assign o_m0_err    = i_rst_n & done_m0_s & err_s;
    assign o_m0_rdata  = (i_rst_n && done_m0_s && !err_s) ? i_lsu_rdata : 32'h0000_0000;

    assign o_m1_ready  = i_rst_n & done_m1_s;
    assign o_m1_err    = i_rst_n & done_m1_s & err_s;
    assign o_m1_rdata  = (i_rst_n && done_m1_s && !err_s) ? i_lsu_rdata : 32'h0000_0000;

    assign o_busy      = i_rst_n & (state_r != ARB_IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lsu_arbiter
// Two arbiter instances (round-robin and fixed priority, TIMEOUT_CYC=8) with
// independent stimulus. Expected completions are queued by the stimulus
// process; a negedge monitor pops and compares whenever a ready appears.
// -----------------------------------------------------------------------------
module tb_lsu_arbiter;
    import singlecycle_pkg::*;

    localparam logic RR = 1'b0;
    localparam logic FX = 1'b1;

    logic clk;
    logic rst_n;

    logic [1:0]       m0_valid, m0_wren, m1_valid, m1_wren, lsu_ready;
    logic [1:0][31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, lsu_rdata;
    logic [1:0][3:0]  m0_strb, m1_strb;

    logic [1:0]       m0_ready, m0_err, m1_ready, m1_err, lsu_valid, lsu_wren, busy;
    logic [1:0][31:0] m0_rdata, m1_rdata, lsu_addr, lsu_wdata;
    logic [1:0][3:0]  lsu_strb;

    typedef struct packed {
        logic        dual;
        logic        m1;
        logic [31:0] rdata;
        logic        err;
        logic        lv;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        wren;
    } exp_t;

    exp_t q_rr[$];
    exp_t q_fx[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    lsu_arbiter #(.ARB_MODE(ARB_RR), .TIMEOUT_CYC(8)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_valid(m0_valid[RR]), .i_m0_addr(m0_addr[RR]), .i_m0_wdata(m0_wdata[RR]),
        .i_m0_strb(m0_strb[RR]), .i_m0_wren(m0_wren[RR]),
        .o_m0_ready(m0_ready[RR]), .o_m0_rdata(m0_rdata[RR]), .o_m0_err(m0_err[RR]),
        .i_m1_valid(m1_valid[RR]), .i_m1_addr(m1_addr[RR]), .i_m1_wdata(m1_wdata[RR]),
        .i_m1_strb(m1_strb[RR]), .i_m1_wren(m1_wren[RR]),
        .o_m1_ready(m1_ready[RR]), .o_m1_rdata(m1_rdata[RR]), .o_m1_err(m1_err[RR]),
        .o_lsu_valid(lsu_valid[RR]), .o_lsu_addr(lsu_addr[RR]), .o_lsu_wdata(lsu_wdata[RR]),
        .o_lsu_strb(lsu_strb[RR]), .o_lsu_wren(lsu_wren[RR]),
        .i_lsu_ready(lsu_ready[RR]), .i_lsu_rdata(lsu_rdata[RR]),
        .o_busy(busy[RR])
    );

    lsu_arbiter #(.ARB_MODE(ARB_FIXED), .TIMEOUT_CYC(8)) u_fx (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_valid(m0_valid[FX]), .i_m0_addr(m0_addr[FX]), .i_m0_wdata(m0_wdata[FX]),
        .i_m0_strb(m0_strb[FX]), .i_m0_wren(m0_wren[FX]),
        .o_m0_ready(m0_ready[FX]), .o_m0_rdata(m0_rdata[FX]), .o_m0_err(m0_err[FX]),
        .i_m1_valid(m1_valid[FX]), .i_m1_addr(m1_addr[FX]), .i_m1_wdata(m1_wdata[FX]),
        .i_m1_strb(m1_strb[FX]), .i_m1_wren(m1_wren[FX]),
        .o_m1_ready(m1_ready[FX]), .o_m1_rdata(m1_rdata[FX]), .o_m1_err(m1_err[FX]),
        .o_lsu_valid(lsu_valid[FX]), .o_lsu_addr(lsu_addr[FX]), .o_lsu_wdata(lsu_wdata[FX]),
        .o_lsu_strb(lsu_strb[FX]), .o_lsu_wren(lsu_wren[FX]),
        .i_lsu_ready(lsu_ready[FX]), .i_lsu_rdata(lsu_rdata[FX]),
        .o_busy(busy[FX])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic chk_all_zero(input logic i, input string name);
        chk(name, 160'({m0_ready[i], m1_ready[i], m0_err[i], m1_err[i], lsu_valid[i],
                        lsu_wren[i], busy[i], lsu_strb[i], m0_rdata[i], m1_rdata[i],
                        lsu_addr[i], lsu_wdata[i]}), 160'(0));
    endtask

    // Queue an expected completion; payload fields come from the bench's own stimulus.
    task automatic push(input logic i, input logic m1, input logic [31:0] rdata,
                        input logic err, input logic lv, input logic [31:0] addr);
        exp_t e;
        e.dual  = 1'b0;
        e.m1    = m1;
        e.rdata = rdata;
        e.err   = err;
        e.lv    = lv;
        e.addr  = addr;
        e.wdata = m1 ? m1_wdata[i] : m0_wdata[i];
        e.strb  = m1 ? m1_strb[i]  : m0_strb[i];
        e.wren  = m1 ? m1_wren[i]  : m0_wren[i];
        if (i == RR) q_rr.push_back(e);
        else         q_fx.push_back(e);
    endtask

    task automatic mon(input logic i);
        exp_t a;
        exp_t e;
        int   sz;
        if (m0_ready[i] || m1_ready[i]) begin
            a.dual  = m0_ready[i] & m1_ready[i];
            a.m1    = m1_ready[i];
            a.rdata = m1_ready[i] ? m1_rdata[i] : m0_rdata[i];
            a.err   = m1_ready[i] ? m1_err[i]   : m0_err[i];
            a.lv    = lsu_valid[i];
            a.addr  = lsu_addr[i];
            a.wdata = lsu_wdata[i];
            a.strb  = lsu_strb[i];
            a.wren  = lsu_wren[i];
            sz = (i == RR) ? q_rr.size() : q_fx.size();
            n_cmp++;
            if (sz == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready inst%0d t=%0t: got m1=%b rdata=%h err=%b required none",
                         i, $time, a.m1, a.rdata, a.err);
            end else begin
                if (i == RR) e = q_rr.pop_front();
                else         e = q_fx.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL completion inst%0d t=%0t: got %h required %h", i, $time, a, e);
                end
            end
        end
    endtask

    // Monitor: compare every completion against the scoreboard.
    always @(negedge clk) begin
        mon(RR);
        mon(FX);
    end

    initial begin
        rst_n     = 1'b0;
        m0_valid  = 2'b11;  m1_valid = 2'b11;  lsu_ready = 2'b11;
        m0_wren   = 2'b00;  m1_wren  = 2'b00;
        m0_addr   = '0;     m1_addr  = '0;
        m0_wdata  = '0;     m1_wdata = '0;
        m0_strb   = '0;     m1_strb  = '0;
        lsu_rdata = '0;
        m0_addr[RR] = 32'h0000_0100; m1_addr[RR] = 32'h0000_0200;
        tick(); tick();
        @(negedge clk);
        chk_all_zero(RR, "reset_rr");
        chk_all_zero(FX, "reset_fx");
        tick();
        m0_valid = 2'b00; m1_valid = 2'b00; lsu_ready = 2'b00;
        rst_n = 1'b1;
        tick();

        // Round-robin, both valid, LSU always ready.
        m0_addr[RR] = 32'h0000_7000; m0_wdata[RR] = 32'h1111_0000; m0_strb[RR] = 4'hF;
        m1_addr[RR] = 32'h0000_7010; m1_wdata[RR] = 32'h2222_0000; m1_strb[RR] = 4'h3;
        m0_valid[RR] = 1'b1; m1_valid[RR] = 1'b1; lsu_ready[RR] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lsu_rdata[RR] = 32'hD000_0000 + 32'(k);
            push(RR, k[0], 32'hD000_0000 + 32'(k), 1'b0, 1'b1,
                 k[0] ? 32'h0000_7010 : 32'h0000_7000);
            @(negedge clk);
            tick();
        end
        m0_valid[RR] = 1'b0; m1_valid[RR] = 1'b0; lsu_ready[RR] = 1'b0;
        tick();

        // Fixed priority: m0 starves m1 until it drops valid.
        m0_addr[FX] = 32'h0000_3000; m1_addr[FX] = 32'h0000_3010;
        m0_valid[FX] = 1'b1; m1_valid[FX] = 1'b1; lsu_ready[FX] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lsu_rdata[FX] = 32'hF000_0000 + 32'(k);
            push(FX, 1'b0, 32'hF000_0000 + 32'(k), 1'b0, 1'b1, 32'h0000_3000);
            @(negedge clk);
            tick();
        end
        m0_valid[FX] = 1'b0; lsu_rdata[FX] = 32'hF000_00AA;
        push(FX, 1'b1, 32'hF000_00AA, 1'b0, 1'b1, 32'h0000_3010);
        @(negedge clk);
        tick();
        m1_valid[FX] = 1'b0; lsu_ready[FX] = 1'b0;
        tick();

        // Multi-cycle m0 read with m1 waiting.
        m0_addr[RR] = 32'h0000_2000; m1_addr[RR] = 32'h0000_2010;
        m0_valid[RR] = 1'b1; m1_valid[RR] = 1'b1; lsu_ready[RR] = 1'b0;
        lsu_rdata[RR] = 32'hFFFF_FFFF;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                lsu_ready[RR] = 1'b1; lsu_rdata[RR] = 32'h1234_5678;
                push(RR, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_2000);
            end
            @(negedge clk);
            chk($sformatf("wait_busy_c%0d", k), 160'(busy[RR]), 160'(k > 1));
            chk($sformatf("wait_addr_c%0d", k), 160'(lsu_addr[RR]), 160'(32'h0000_2000));
            chk($sformatf("wait_valid_c%0d", k), 160'(lsu_valid[RR]), 160'(1'b1));
            tick();
        end
        lsu_rdata[RR] = 32'h0000_5A5A;
        push(RR, 1'b1, 32'h0000_5A5A, 1'b0, 1'b1, 32'h0000_2010);
        @(negedge clk);
        tick();
        m0_valid[RR] = 1'b0; m1_valid[RR] = 1'b0; lsu_ready[RR] = 1'b0;
        tick();

        // m1 write times out after 8 cycles without LSU ready.
        m1_addr[RR] = 32'h0000_4000; m1_wdata[RR] = 32'h0000_0055; m1_strb[RR] = 4'hF;
        m1_wren[RR] = 1'b1; m1_valid[RR] = 1'b1; lsu_rdata[RR] = 32'hDEAD_BEEF;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) push(RR, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_4000);
            @(negedge clk);
            chk($sformatf("to_busy_c%0d", k), 160'(busy[RR]), 160'(k > 1));
            if (k < 8) chk($sformatf("to_valid_c%0d", k), 160'(lsu_valid[RR]), 160'(1'b1));
            tick();
        end
        m0_addr[RR] = 32'h0000_4100; m0_valid[RR] = 1'b1;
        lsu_ready[RR] = 1'b1; lsu_rdata[RR] = 32'h0000_0009;
        push(RR, 1'b0, 32'h0000_0009, 1'b0, 1'b1, 32'h0000_4100);
        @(negedge clk);
        chk("after_to_busy", 160'(busy[RR]), 160'(1'b0));
        tick();
        m0_valid[RR] = 1'b0; m1_valid[RR] = 1'b0; lsu_ready[RR] = 1'b0;
        tick();

        // Reset in the middle of a BUSY_M0 transaction.
        m0_addr[RR] = 32'h0000_5000; m0_valid[RR] = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("pre_rst_busy", 160'(busy[RR]), 160'(1'b1));
        tick();
        rst_n = 1'b0; lsu_ready[RR] = 1'b1; m1_addr[RR] = 32'h0000_5010; m1_valid[RR] = 1'b1;
        @(negedge clk);
        chk_all_zero(RR, "midrst_c1");
        tick();
        @(negedge clk);
        chk_all_zero(RR, "midrst_c2");
        chk_all_zero(FX, "midrst_fx");
        tick();
        rst_n = 1'b1; lsu_rdata[RR] = 32'h0000_0055;
        push(RR, 1'b0, 32'h0000_0055, 1'b0, 1'b1, 32'h0000_5000);
        @(negedge clk);
        tick();
        m0_valid[RR] = 1'b0; m1_valid[RR] = 1'b0; lsu_ready[RR] = 1'b0;
        tick();

        // m0 partial store forwarded in the request cycle.
        m0_addr[RR] = 32'h0000_6000; m0_wdata[RR] = 32'hAABB_CCDD; m0_strb[RR] = 4'b0011;
        m0_wren[RR] = 1'b1; m0_valid[RR] = 1'b1;
        @(negedge clk);
        chk("st_strb",  160'(lsu_strb[RR]),  160'(4'b0011));
        chk("st_wdata", 160'(lsu_wdata[RR]), 160'(32'hAABB_CCDD));
        chk("st_wren",  160'(lsu_wren[RR]),  160'(1'b1));
        chk("st_valid", 160'(lsu_valid[RR]), 160'(1'b1));
        tick();
        lsu_ready[RR] = 1'b1; lsu_rdata[RR] = 32'h0BAD_F00D;
        push(RR, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b1, 32'h0000_6000);
        @(negedge clk);
        tick();
        m0_valid[RR] = 1'b0; lsu_ready[RR] = 1'b0;
        tick();
        @(negedge clk);

        chk("rr_queue_drained", 160'(q_rr.size()), 160'(0));
        chk("fx_queue_drained", 160'(q_fx.size()), 160'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
